// File: rtl/button_event_arbiter_pkg.sv
// Shared event encodings and FIFO entry sizing for the button event arbiter.
package button_event_arbiter_pkg;

    typedef enum logic [1:0] {
        EVT_NONE    = 2'b00,
        EVT_PRESS   = 2'b01,
        EVT_RELEASE = 2'b10,
        EVT_LONG    = 2'b11
    } evt_type_e;

    // FIFO entry layout is {id, type}.
    function automatic int unsigned evt_entry_width(input int unsigned n_btn);
        return $clog2(n_btn) + 2;
    endfunction

endpackage

// File: rtl/button_event_arbiter_sync_fifo.sv
// Generic synchronous FIFO with a registered head entry and occupancy count.
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    input  logic                     pop,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    // A push into a full FIFO is legal when the head leaves in the same cycle.
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/button_event_arbiter.sv
// Serialises per-button press/release (and long-press when LONG_PRESS_EN is
// defined) pulses through a round-robin arbiter into a valid/ready event FIFO.
module button_event_arbiter
    import button_event_arbiter_pkg::*;
#(
    parameter int unsigned N_BTN      = 4,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned LONG_TICKS = 200
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          tick,
    input  logic [N_BTN-1:0]              btn_level,
    input  logic [N_BTN-1:0]              btn_rise,
    input  logic [N_BTN-1:0]              btn_fall,
    output logic                          evt_valid,
    input  logic                          evt_ready,
    output logic [$clog2(N_BTN)-1:0]      evt_id,
    output logic [1:0]                    evt_type,
    output logic [$clog2(FIFO_DEPTH):0]   evt_count,
    output logic                          evt_drop
);

    localparam int unsigned IDW = $clog2(N_BTN);
    localparam int unsigned EW  = evt_entry_width(N_BTN);

    logic [N_BTN-1:0] rise_pend, fall_pend, long_pend;
    logic [N_BTN-1:0] clr_rise, clr_fall, clr_long;
    logic [N_BTN-1:0] lost_long;
    logic [N_BTN-1:0] cand;
    logic [IDW-1:0]   rr_ptr;
    logic             grant;
    logic [IDW-1:0]   win_id;
    evt_type_e        win_type;
    logic [N_BTN-1:0] win_onehot;
    logic             fifo_full, fifo_empty, pop;
    logic [EW-1:0]    fifo_dout;

    assign cand      = rise_pend | fall_pend | long_pend;
    assign pop       = !fifo_empty && evt_ready;
    assign evt_valid = !fifo_empty;
    assign evt_id    = fifo_dout[EW-1:2];
    assign evt_type  = fifo_dout[1:0];

    always_comb begin
        logic [IDW-1:0] sel;
        grant    = 1'b0;
        win_id   = '0;
        win_type = EVT_NONE;
        sel      = '0;
        for (int unsigned k = 0; k < N_BTN; k++) begin
            sel = IDW'((32'(rr_ptr) + k) % N_BTN);
            if (!grant && cand[sel]) begin
                grant  = 1'b1;
                win_id = sel;
                // Rise before long before fall keeps press ahead of release.
                if (rise_pend[sel])      win_type = EVT_PRESS;
                else if (long_pend[sel]) win_type = EVT_LONG;
                else                     win_type = EVT_RELEASE;
            end
        end
        if (fifo_full && !pop) grant = 1'b0;
    end

    assign win_onehot = grant ? (N_BTN'(1) << win_id) : '0;
    assign clr_rise   = win_onehot & {N_BTN{win_type == EVT_PRESS}};
    assign clr_fall   = win_onehot & {N_BTN{win_type == EVT_RELEASE}};
    assign clr_long   = win_onehot & {N_BTN{win_type == EVT_LONG}};

    always_ff @(posedge clk) begin
        if (rst) begin
            rise_pend <= '0;
            fall_pend <= '0;
            rr_ptr    <= '0;
            evt_drop  <= 1'b0;
        end else begin
            rise_pend <= (rise_pend & ~clr_rise) | btn_rise;
            fall_pend <= (fall_pend & ~clr_fall) | btn_fall;
            if (|(btn_rise & rise_pend & ~clr_rise) || |(btn_fall & fall_pend & ~clr_fall) ||
                |lost_long) begin
                evt_drop <= 1'b1;
            end
            if (grant) begin
                rr_ptr <= (win_id == IDW'(N_BTN-1)) ? '0 : win_id + 1'b1;
            end
        end
    end

`ifdef LONG_PRESS_EN
    localparam int unsigned CNTW = $clog2(LONG_TICKS + 1);

    logic [CNTW-1:0]  hold_cnt [N_BTN];
    logic [N_BTN-1:0] long_hit;

    always_comb begin
        for (int unsigned b = 0; b < N_BTN; b++) begin
            long_hit[b] = tick && btn_level[b] && (hold_cnt[b] == CNTW'(LONG_TICKS - 1));
        end
    end

    assign lost_long = long_hit & long_pend & ~clr_long;

    always_ff @(posedge clk) begin
        if (rst) begin
            long_pend <= '0;
            for (int unsigned b = 0; b < N_BTN; b++) begin
                hold_cnt[b] <= '0;
            end
        end else begin
            long_pend <= (long_pend & ~clr_long) | long_hit;
            for (int unsigned b = 0; b < N_BTN; b++) begin
                if (!btn_level[b]) begin
                    hold_cnt[b] <= '0;
                end else if (tick && (hold_cnt[b] < CNTW'(LONG_TICKS))) begin
                    hold_cnt[b] <= hold_cnt[b] + 1'b1;
                end
            end
        end
    end
`else
    logic unused_inputs;

    assign long_pend     = '0;
    assign lost_long     = '0;
    assign unused_inputs = ^{tick, btn_level, clr_long, 32'(LONG_TICKS)};
`endif

    sync_fifo #(
        .WIDTH (EW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (grant),
        .din   ({win_id, win_type}),
        .pop   (pop),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (evt_count)
    );

endmodule

// File: tb/tb_button_event_arbiter.sv
// Self-checking bench for button_event_arbiter: directed scenarios plus random
// traffic, all checked against a queue-based reference model.
module tb_button_event_arbiter;

    localparam int unsigned NB = 4;
    localparam int unsigned FD = 4;
    localparam int unsigned LT = 5;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          tick = 1'b0;
    logic [NB-1:0] btn_level = '0;
    logic [NB-1:0] btn_rise = '0;
    logic [NB-1:0] btn_fall = '0;
    logic          evt_valid;
    logic          evt_ready = 1'b0;
    logic [1:0]    evt_id;
    logic [1:0]    evt_type;
    logic [2:0]    evt_count;
    logic          evt_drop;

    int unsigned checks = 0;
    int unsigned errors = 0;

    // Reference model: pending bits per button, an event queue, RR pointer.
    bit          m_rp [NB];
    bit          m_fp [NB];
    bit          m_lp [NB];
    int unsigned m_cnt [NB];
    int unsigned m_rr;
    bit          m_drop;
    logic [3:0]  m_q [$];
    logic [3:0]  delivered [$];

    always #5 clk = ~clk;

    button_event_arbiter #(
        .N_BTN      (NB),
        .FIFO_DEPTH (FD),
        .LONG_TICKS (LT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .tick      (tick),
        .btn_level (btn_level),
        .btn_rise  (btn_rise),
        .btn_fall  (btn_fall),
        .evt_valid (evt_valid),
        .evt_ready (evt_ready),
        .evt_id    (evt_id),
        .evt_type  (evt_type),
        .evt_count (evt_count),
        .evt_drop  (evt_drop)
    );

    task automatic model_update();
        int  win;
        bit  pop;
        bit  can;
        int unsigned b;
        logic [1:0] ty;
        if (rst) begin
            for (int i = 0; i < NB; i++) begin
                m_rp[i] = 0; m_fp[i] = 0; m_lp[i] = 0; m_cnt[i] = 0;
            end
            m_rr = 0; m_drop = 0; m_q.delete();
            return;
        end
        pop = (m_q.size() != 0) && evt_ready;
        can = (m_q.size() < FD) || pop;
        win = -1;
        for (int unsigned k = 0; k < NB; k++) begin
            b = (m_rr + k) % NB;
            if (win < 0 && (m_rp[b] || m_fp[b] || m_lp[b])) win = int'(b);
        end
        if (pop) void'(m_q.pop_front());
        if (win >= 0 && can) begin
            if (m_rp[win])      begin ty = 2'b01; m_rp[win] = 0; end
            else if (m_lp[win]) begin ty = 2'b11; m_lp[win] = 0; end
            else                begin ty = 2'b10; m_fp[win] = 0; end
            m_q.push_back({2'(win), ty});
            m_rr = (int'(win) + 1) % NB;
        end
`ifdef LONG_PRESS_EN
        for (int i = 0; i < NB; i++) begin
            if (!btn_level[i]) m_cnt[i] = 0;
            else if (tick && m_cnt[i] < LT) begin
                m_cnt[i]++;
                if (m_cnt[i] == LT) begin
                    if (m_lp[i]) m_drop = 1;
                    m_lp[i] = 1;
                end
            end
        end
`endif
        for (int i = 0; i < NB; i++) begin
            if (btn_rise[i]) begin if (m_rp[i]) m_drop = 1; m_rp[i] = 1; end
            if (btn_fall[i]) begin if (m_fp[i]) m_drop = 1; m_fp[i] = 1; end
        end
    endtask

    // One clock: record DUT pops, advance model, then compare away from the edge.
    task automatic step();
        if (evt_valid && evt_ready) delivered.push_back({evt_id, evt_type});
        model_update();
        @(posedge clk);
        #1;
        btn_rise = '0;
        btn_fall = '0;
        tick     = 1'b0;
        checks++;
        if (evt_count !== 3'(m_q.size())) begin
            errors++; $display("FAIL model_count got %0d want %0d", evt_count, m_q.size());
        end
        checks++;
        if (evt_valid !== (m_q.size() != 0)) begin
            errors++; $display("FAIL model_valid got %0b want %0b", evt_valid, m_q.size() != 0);
        end
        checks++;
        if (evt_drop !== m_drop) begin
            errors++; $display("FAIL model_drop got %0b want %0b", evt_drop, m_drop);
        end
        if (m_q.size() != 0) begin
            checks++;
            if ({evt_id, evt_type} !== m_q[0]) begin
                errors++; $display("FAIL model_head got %0h want %0h", {evt_id, evt_type}, m_q[0]);
            end
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        evt_ready = 1'b1;
        btn_rise  = 4'b1111;
        btn_fall  = 4'b1111;
        rst       = 1'b1;
        step();
        step();
        rst = 1'b0;
        checks++;
        if ({evt_valid, evt_id, evt_type, evt_count, evt_drop} !== 9'd0) begin
            errors++;
            $display("FAIL reset_outputs got v=%0b id=%0d ty=%0d cnt=%0d drop=%0b want all 0",
                     evt_valid, evt_id, evt_type, evt_count, evt_drop);
        end
    endtask

    task automatic test_single();
        do_reset();
        evt_ready = 1'b1;
        btn_rise  = 4'b0100;
        step();
        checks++;
        if (evt_valid !== 1'b0) begin errors++; $display("FAIL single_early got %0b want 0", evt_valid); end
        step();
        checks++;
        if ({evt_valid, evt_id, evt_type, evt_count} !== {1'b1, 2'd2, 2'b01, 3'd1}) begin
            errors++;
            $display("FAIL single_event got v=%0b id=%0d ty=%0d cnt=%0d want v=1 id=2 ty=1 cnt=1",
                     evt_valid, evt_id, evt_type, evt_count);
        end
        step();
        checks++;
        if (evt_count !== 3'd0) begin errors++; $display("FAIL single_drain got %0d want 0", evt_count); end
    endtask

    task automatic test_same_cycle();
        logic [3:0] exp [3];
        exp = '{4'b0001, 4'b0101, 4'b1101};
        do_reset();
        evt_ready = 1'b1;
        delivered.delete();
        btn_rise = 4'b1011;
        for (int i = 0; i < 6; i++) step();
        checks++;
        if (delivered.size() != 3) begin
            errors++; $display("FAIL rr_len got %0d want 3", delivered.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (delivered[i] !== exp[i]) begin
                    errors++; $display("FAIL rr_order[%0d] got %0h want %0h", i, delivered[i], exp[i]);
                end
            end
        end
    endtask

    task automatic test_full();
        logic [3:0] exp [6];
        exp = '{4'b0001, 4'b0101, 4'b1001, 4'b1101, 4'b0010, 4'b0110};
        do_reset();
        evt_ready = 1'b0;
        btn_rise  = 4'b1111;
        btn_fall  = 4'b0011;
        for (int i = 0; i < 8; i++) step();
        checks++;
        if ({evt_count, evt_drop} !== {3'd4, 1'b0}) begin
            errors++; $display("FAIL full_hold got cnt=%0d drop=%0b want cnt=4 drop=0", evt_count, evt_drop);
        end
        evt_ready = 1'b1;
        delivered.delete();
        for (int i = 0; i < 10; i++) step();
        checks++;
        if (delivered.size() != 6) begin
            errors++; $display("FAIL full_len got %0d want 6", delivered.size());
        end else begin
            for (int i = 0; i < 6; i++) begin
                checks++;
                if (delivered[i] !== exp[i]) begin
                    errors++; $display("FAIL full_order[%0d] got %0h want %0h", i, delivered[i], exp[i]);
                end
            end
        end
    endtask

    task automatic test_drop();
        int unsigned n1;
        do_reset();
        evt_ready = 1'b0;
        btn_rise  = 4'b1101;
        step();
        btn_fall = 4'b0001;
        step();
        for (int i = 0; i < 5; i++) step();
        checks++;
        if (evt_count !== 3'd4) begin errors++; $display("FAIL drop_fill got %0d want 4", evt_count); end
        btn_rise = 4'b0010;
        step(); step(); step();
        btn_rise = 4'b0010;
        step();
        step(); step();
        checks++;
        if (evt_drop !== 1'b1) begin errors++; $display("FAIL drop_flag got %0b want 1", evt_drop); end
        evt_ready = 1'b1;
        delivered.delete();
        for (int i = 0; i < 10; i++) step();
        n1 = 0;
        foreach (delivered[i]) if (delivered[i] == 4'b0101) n1++;
        checks++;
        if (n1 != 1) begin errors++; $display("FAIL drop_single_press got %0d want 1", n1); end
        checks++;
        if (evt_drop !== 1'b1) begin errors++; $display("FAIL drop_sticky got %0b want 1", evt_drop); end
    endtask

    task automatic test_order();
        do_reset();
        evt_ready = 1'b1;
        delivered.delete();
        btn_rise  = 4'b0001;
        btn_fall  = 4'b0001;
        for (int i = 0; i < 5; i++) step();
        checks++;
        if (delivered.size() != 2 || delivered[0] !== 4'b0001 || delivered[1] !== 4'b0010) begin
            errors++;
            $display("FAIL press_before_release got n=%0d first=%0h want n=2 first=1 second=2",
                     delivered.size(), delivered.size() ? delivered[0] : 4'hx);
        end
    endtask

`ifdef LONG_PRESS_EN
    task automatic test_long();
        do_reset();
        evt_ready = 1'b1;
        delivered.delete();
        btn_level = 4'b0010;
        btn_rise  = 4'b0010;
        step();
        for (int t = 0; t < 8; t++) begin
            tick = 1'b1;
            step(); step(); step();
        end
        btn_level = 4'b0000;
        btn_fall  = 4'b0010;
        for (int i = 0; i < 5; i++) step();
        checks++;
        if (delivered.size() != 3 || delivered[0] !== 4'b0101 || delivered[1] !== 4'b0111 ||
            delivered[2] !== 4'b0110) begin
            errors++; $display("FAIL long_sequence got n=%0d want press,long,release", delivered.size());
        end
        btn_level = 4'b0010;
        btn_rise  = 4'b0010;
        step(); step(); step();
        for (int t = 0; t < 3; t++) begin tick = 1'b1; step(); step(); end
        rst = 1'b1;
        step();
        rst = 1'b0;
        delivered.delete();
        for (int t = 0; t < 3; t++) begin tick = 1'b1; step(); step(); end
        btn_level = 4'b0000;
        for (int i = 0; i < 4; i++) step();
        checks++;
        if (delivered.size() != 0 || evt_count !== 3'd0) begin
            errors++; $display("FAIL long_reset got n=%0d cnt=%0d want 0 0", delivered.size(), evt_count);
        end
    endtask
`endif

    task automatic test_back_to_back();
        do_reset();
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 15) == 0) btn_level[$urandom_range(0, NB-1)] ^= 1'b1;
            btn_rise  = 4'($urandom & $urandom);
            btn_fall  = 4'($urandom & $urandom);
            tick      = ($urandom_range(0, 3) == 0);
            evt_ready = ($urandom_range(0, 3) != 0);
            rst       = ($urandom_range(0, 499) == 0);
            step();
        end
        rst       = 1'b0;
        btn_level = '0;
        evt_ready = 1'b1;
        for (int i = 0; i < 30; i++) step();
        checks++;
        if (evt_count !== 3'd0) begin errors++; $display("FAIL b2b_drain got %0d want 0", evt_count); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_same_cycle();
        test_full();
        test_drop();
        test_order();
`ifdef LONG_PRESS_EN
        test_long();
`endif
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
